// File: rtl/draw_engine_pkg.sv
// draw_engine_pkg: shared screen geometry, widths, command/state enums and the
// position payload used by the draw_engine slice.
package draw_engine_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  // Which drawing command is in flight; selects colour, origin and done flag.
  typedef enum logic [2:0] {
    CMD_BG,
    CMD_WIN,
    CMD_CAR,
    CMD_NEW_BG,
    CMD_NEW_CAR
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RECT
  } state_e;

  // Top-left pixel of a car-sized rectangle.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

endpackage

// File: rtl/draw_engine_if.sv
// draw_engine_if: controller <-> draw_engine bundle.
//   master (game controller): drives command levels, move and direction,
//                             observes the pixel port, done levels and win.
//   slave  (draw_engine):     the reverse.
interface draw_engine_if;
  import draw_engine_pkg::*;

  logic                draw_background;
  logic                draw_car;
  logic                draw_new_background;
  logic                draw_new_car;
  logic                draw_win_screen;
  logic                move;
  logic                forward;
  logic                left;
  logic                right;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                done1;
  logic                done2;
  logic                done1_new;
  logic                done2_new;
  logic                done3;
  logic                win;

  modport master (
    output draw_background, draw_car, draw_new_background, draw_new_car,
           draw_win_screen, move, forward, left, right,
    input  x, y, colour, plot, done1, done2, done1_new, done2_new, done3, win
  );

  modport slave (
    input  draw_background, draw_car, draw_new_background, draw_new_car,
           draw_win_screen, move, forward, left, right,
    output x, y, colour, plot, done1, done2, done1_new, done2_new, done3, win
  );

endinterface

// File: rtl/draw_engine_car_sprite_rom.sv
// car_sprite_rom: 8x8 one-bit-per-pixel car bitmap, combinational lookup.
//   row     in 3 : bitmap row (car-relative y)
//   col     in 3 : bitmap column (car-relative x)
//   pixel_c out 1: 1 = car pixel, 0 = transparent
module car_sprite_rom (
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       pixel_c
);

  logic [7:0] bits;

  always_comb begin
    bits = 8'h00;
    case (row)
      3'd0: bits = 8'b0011_1100;
      3'd1: bits = 8'b0111_1110;
      3'd2: bits = 8'b1101_1011;
      3'd3: bits = 8'b0111_1110;
      3'd4: bits = 8'b0111_1110;
      3'd5: bits = 8'b1101_1011;
      3'd6: bits = 8'b0111_1110;
      3'd7: bits = 8'b0011_1100;
      default: bits = 8'h00;
    endcase
    pixel_c = bits[col];
  end

endmodule

// File: rtl/draw_engine.sv
// draw_engine: car position keeper and one-pixel-per-cycle rectangle drawer
// feeding the 160x120 VGA adapter.
//   Clock, reset (sync, active-high), set_reset_signals (soft reset)
//   bus (draw_engine_if.slave): command levels, move/direction in;
//       registered x/y/colour/plot, done levels and win out.
// Build option: DRAW_ENGINE_SPRITE_EN draws car/new_car from an 8x8 bitmap,
// with 0 bits consuming their cycle at plot=0.
module draw_engine
  import draw_engine_pkg::*;
#(
  parameter int unsigned         CAR_W      = 8,
  parameter int unsigned         CAR_H      = 8,
  parameter int unsigned         STEP       = 4,
  parameter int unsigned         START_X    = 76,
  parameter int unsigned         START_Y    = 108,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b010,
  parameter logic [COLOUR_W-1:0] CAR_COLOUR = 3'b100,
  parameter logic [COLOUR_W-1:0] WIN_COLOUR = 3'b110
) (
  input  logic          Clock,
  input  logic          reset,
  input  logic          set_reset_signals,
  draw_engine_if.slave  bus
);

  localparam int unsigned       X_MAX   = SCREEN_W - CAR_W;
  localparam logic signed [8:0] STEP_S  = 9'(STEP);
  localparam logic signed [8:0] X_MAX_S = 9'(X_MAX);

  state_e              state;
  cmd_e                cmd;
  pos_t                cur;
  pos_t                pend;
  pos_t                org;
  logic [X_W-1:0]      cnt_x;
  logic [Y_W-1:0]      cnt_y;
  logic [X_W-1:0]      last_x;
  logic [Y_W-1:0]      last_y;
  logic                scan_end;
  logic [COLOUR_W-1:0] draw_colour;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q;
  logic                done1_q, done2_q, done1_new_q, done2_new_q, done3_q;
  logic                win_q;
  logic                pixel_on;
  logic signed [8:0]   px_s;
  logic signed [8:0]   py_s;

`ifdef DRAW_ENGINE_SPRITE_EN
  logic sprite_px;

  car_sprite_rom u_sprite (
    .row     (cnt_y[2:0]),
    .col     (cnt_x[2:0]),
    .pixel_c (sprite_px)
  );

  assign pixel_on = (cmd == CMD_CAR || cmd == CMD_NEW_CAR) ? sprite_px : 1'b1;
`else
  assign pixel_on = 1'b1;
`endif

  // Pending position: one step in the highest-priority direction, clamped on-screen.
  always_comb begin
    pend = '0;
    px_s = $signed({1'b0, cur.x});
    py_s = $signed({2'b00, cur.y});
    if (bus.forward)    py_s = py_s - STEP_S;
    else if (bus.left)  px_s = px_s - STEP_S;
    else if (bus.right) px_s = px_s + STEP_S;
    if (px_s < 9'sd0)        pend.x = '0;
    else if (px_s > X_MAX_S) pend.x = X_W'(X_MAX);
    else                     pend.x = px_s[X_W-1:0];
    pend.y = (py_s < 9'sd0) ? '0 : py_s[Y_W-1:0];
  end

  // Scan extent for the current state.
  assign last_x = (state == FILL) ? X_W'(SCREEN_W - 1) : X_W'(CAR_W - 1);
  assign last_y = (state == FILL) ? Y_W'(SCREEN_H - 1) : Y_W'(CAR_H - 1);

  // Controller FSM, position/win registers and registered pixel port.
  always_ff @(posedge Clock) begin
    if (reset || set_reset_signals) begin
      state       <= IDLE;
      cmd         <= CMD_BG;
      cur         <= '{x: X_W'(START_X), y: Y_W'(START_Y)};
      org         <= '0;
      cnt_x       <= '0;
      cnt_y       <= '0;
      scan_end    <= 1'b0;
      draw_colour <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      done1_q     <= 1'b0;
      done2_q     <= 1'b0;
      done1_new_q <= 1'b0;
      done2_new_q <= 1'b0;
      done3_q     <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      // Done levels drop once their command is released; a finish below overrides.
      if (!bus.draw_background)     done1_q     <= 1'b0;
      if (!bus.draw_car)            done2_q     <= 1'b0;
      if (!bus.draw_new_background) done1_new_q <= 1'b0;
      if (!bus.draw_new_car)        done2_new_q <= 1'b0;
      if (!bus.draw_win_screen)     done3_q     <= 1'b0;

      case (state)
        IDLE: begin
          plot_q   <= 1'b0;
          cnt_x    <= '0;
          cnt_y    <= '0;
          scan_end <= 1'b0;
          if (bus.move) begin
            cur <= pend;
            if (pend.y == '0) win_q <= 1'b1;
          end
          if (bus.draw_win_screen && !done3_q) begin
            state <= FILL; cmd <= CMD_WIN; org <= '0; draw_colour <= WIN_COLOUR;
          end else if (bus.draw_background && !done1_q) begin
            state <= FILL; cmd <= CMD_BG; org <= '0; draw_colour <= BG_COLOUR;
          end else if (bus.draw_new_background && !done1_new_q) begin
            state <= RECT; cmd <= CMD_NEW_BG; org <= cur; draw_colour <= BG_COLOUR;
          end else if (bus.draw_car && !done2_q) begin
            state <= RECT; cmd <= CMD_CAR; org <= cur; draw_colour <= CAR_COLOUR;
          end else if (bus.draw_new_car && !done2_new_q) begin
            state <= RECT; cmd <= CMD_NEW_CAR; org <= pend; draw_colour <= CAR_COLOUR;
          end
        end
        FILL, RECT: begin
          if (scan_end) begin
            // Cycle after the last pixel: report completion and return.
            plot_q <= 1'b0;
            state  <= IDLE;
            case (cmd)
              CMD_BG:      done1_q     <= 1'b1;
              CMD_WIN:     done3_q     <= 1'b1;
              CMD_CAR:     done2_q     <= 1'b1;
              CMD_NEW_BG:  done1_new_q <= 1'b1;
              CMD_NEW_CAR: done2_new_q <= 1'b1;
              default:     ;
            endcase
          end else begin
            x_q      <= org.x + cnt_x;
            y_q      <= org.y + cnt_y;
            colour_q <= draw_colour;
            plot_q   <= pixel_on;
            scan_end <= (cnt_x == last_x) && (cnt_y == last_y);
            if (cnt_x == last_x) begin
              cnt_x <= '0;
              cnt_y <= cnt_y + Y_W'(1);
            end else begin
              cnt_x <= cnt_x + X_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.done1     = done1_q;
  assign bus.done2     = done2_q;
  assign bus.done1_new = done1_new_q;
  assign bus.done2_new = done2_new_q;
  assign bus.done3     = done3_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_draw_engine.sv
// tb_draw_engine: directed self-checking bench for draw_engine (default build).
module tb_draw_engine;
  import draw_engine_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic srs;
  int   errors = 0;
  int   checks = 0;

  // Per-draw statistics filled by collect().
  int n_plot, n_badcol, first_cyc, last_cyc, done_cyc, plot_at_done, timed_out;
  int fx, fy, lx, ly, minx, maxx, miny, maxy;

  draw_engine_if bus();

  draw_engine dut (
    .Clock             (clk),
    .reset             (reset),
    .set_reset_signals (srs),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  function automatic logic get_done(input int sel);
    case (sel)
      1: return bus.done1;
      2: return bus.done2;
      3: return bus.done1_new;
      4: return bus.done2_new;
      5: return bus.done3;
      default: return 1'b0;
    endcase
  endfunction

  // Records plot activity on negedges until the selected done rises or the budget runs out.
  task automatic collect(input int sel, input logic [2:0] col);
    int cyc;
    cyc = 0; n_plot = 0; n_badcol = 0; first_cyc = -1; last_cyc = -1;
    done_cyc = -1; plot_at_done = -1; timed_out = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; minx = 999; maxx = -1; miny = 999; maxy = -1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (get_done(sel)) begin
        done_cyc = cyc; plot_at_done = int'(bus.plot);
        break;
      end
      if (bus.plot) begin
        if (n_plot == 0) begin fx = int'(bus.x); fy = int'(bus.y); first_cyc = cyc; end
        lx = int'(bus.x); ly = int'(bus.y); last_cyc = cyc;
        if (int'(bus.x) < minx) minx = int'(bus.x);
        if (int'(bus.x) > maxx) maxx = int'(bus.x);
        if (int'(bus.y) < miny) miny = int'(bus.y);
        if (int'(bus.y) > maxy) maxy = int'(bus.y);
        if (bus.colour !== col) n_badcol++;
        n_plot++;
      end
      if (cyc > 25000) begin timed_out = 1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic move_once(input logic f, input logic l, input logic r);
    @(negedge clk);
    bus.forward = f; bus.left = l; bus.right = r; bus.move = 1'b1;
    @(negedge clk);
    bus.move = 1'b0; bus.forward = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b exp 0", bus.plot); end
    checks++; if (bus.x !== 8'd0 || bus.y !== 7'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", bus.x, bus.y); end
    checks++; if (bus.colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d exp 0", bus.colour); end
    checks++; if ({bus.done1, bus.done2, bus.done1_new, bus.done2_new, bus.done3} !== 5'b0) begin
      errors++; $display("FAIL reset_done got %b exp 00000", {bus.done1, bus.done2, bus.done1_new, bus.done2_new, bus.done3}); end
    checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL reset_win got %b exp 0", bus.win); end
  endtask

  task automatic test_background();
    @(negedge clk);
    bus.draw_background = 1'b1;
    collect(1, 3'b010);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL bg_timeout got %0d exp 0", timed_out); end
    checks++; if (n_plot != 19200) begin errors++; $display("FAIL bg_count got %0d exp 19200", n_plot); end
    checks++; if (fx != 0 || fy != 0) begin errors++; $display("FAIL bg_first got %0d,%0d exp 0,0", fx, fy); end
    checks++; if (lx != 159 || ly != 119) begin errors++; $display("FAIL bg_last got %0d,%0d exp 159,119", lx, ly); end
    checks++; if (n_badcol != 0) begin errors++; $display("FAIL bg_colour got %0d bad exp 0", n_badcol); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL bg_latency got %0d exp 2", first_cyc); end
    checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL bg_done_time got %0d exp %0d", done_cyc, last_cyc + 1); end
    checks++; if (plot_at_done != 0) begin errors++; $display("FAIL bg_plot_at_done got %0d exp 0", plot_at_done); end
    bus.draw_background = 1'b0;
    @(negedge clk);
    checks++; if (bus.done1 !== 1'b0) begin errors++; $display("FAIL bg_done_clear got %b exp 0", bus.done1); end
  endtask

  task automatic test_car();
    @(negedge clk);
    bus.draw_car = 1'b1;
    collect(2, 3'b100);
    bus.draw_car = 1'b0;
    checks++; if (timed_out != 0) begin errors++; $display("FAIL car_timeout got %0d exp 0", timed_out); end
    checks++; if (n_plot != 64) begin errors++; $display("FAIL car_count got %0d exp 64", n_plot); end
    checks++; if (minx != 76 || maxx != 83) begin errors++; $display("FAIL car_xrange got %0d..%0d exp 76..83", minx, maxx); end
    checks++; if (miny != 108 || maxy != 115) begin errors++; $display("FAIL car_yrange got %0d..%0d exp 108..115", miny, maxy); end
    checks++; if (fx != 76 || fy != 108 || lx != 83 || ly != 115) begin
      errors++; $display("FAIL car_order got %0d,%0d..%0d,%0d exp 76,108..83,115", fx, fy, lx, ly); end
    checks++; if (n_badcol != 0) begin errors++; $display("FAIL car_colour got %0d bad exp 0", n_badcol); end
    checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL car_done_time got %0d exp %0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 20; i++) move_once(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.draw_car = 1'b1;
    collect(2, 3'b100);
    bus.draw_car = 1'b0;
    checks++; if (minx != 0 || maxx != 7) begin errors++; $display("FAIL clamp_left got %0d..%0d exp 0..7", minx, maxx); end
    for (int i = 0; i < 39; i++) move_once(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.draw_car = 1'b1;
    collect(2, 3'b100);
    bus.draw_car = 1'b0;
    checks++; if (minx != 152 || maxx != 159) begin errors++; $display("FAIL clamp_right got %0d..%0d exp 152..159", minx, maxx); end
    checks++; if (miny != 108) begin errors++; $display("FAIL clamp_y got %0d exp 108", miny); end
  endtask

  task automatic test_move_to_win();
    int cy;
    do_reset();
    bus.forward = 1'b1;
    for (int k = 0; k < 27; k++) begin
      cy = 108 - 4 * k;
      @(negedge clk);
      bus.draw_new_background = 1'b1;
      collect(3, 3'b010);
      bus.draw_new_background = 1'b0;
      checks++; if (n_plot != 64 || miny != cy || minx != 76) begin
        errors++; $display("FAIL erase_%0d got n=%0d x=%0d y=%0d exp n=64 x=76 y=%0d", k, n_plot, minx, miny, cy); end
      @(negedge clk);
      bus.draw_new_car = 1'b1;
      collect(4, 3'b100);
      bus.draw_new_car = 1'b0;
      checks++; if (n_plot != 64 || miny != cy - 4 || n_badcol != 0) begin
        errors++; $display("FAIL newcar_%0d got n=%0d y=%0d bad=%0d exp n=64 y=%0d bad=0", k, n_plot, miny, n_badcol, cy - 4); end
      @(negedge clk);
      bus.move = 1'b1;
      @(negedge clk);
      bus.move = 1'b0;
      checks++; if (bus.win !== ((cy - 4) == 0)) begin
        errors++; $display("FAIL win_%0d got %b exp %b", k, bus.win, ((cy - 4) == 0)); end
      if (k == 0) begin
        @(negedge clk);
        bus.draw_car = 1'b1;
        collect(2, 3'b100);
        bus.draw_car = 1'b0;
        checks++; if (miny != 104 || minx != 76) begin errors++; $display("FAIL pos_after_move got %0d,%0d exp 76,104", minx, miny); end
      end
    end
    bus.forward = 1'b0;
    @(negedge clk);
    bus.draw_car = 1'b1;
    collect(2, 3'b100);
    bus.draw_car = 1'b0;
    checks++; if (miny != 0 || maxy != 7) begin errors++; $display("FAIL pos_top got %0d..%0d exp 0..7", miny, maxy); end
  endtask

  task automatic test_soft_reset();
    int cyc;
    int npl;
    move_once(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.draw_background = 1'b1;
    cyc = 0; npl = 0;
    while (npl < 500 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.plot) npl++;
    end
    checks++; if (npl != 500) begin errors++; $display("FAIL srst_reach500 got %0d exp 500", npl); end
    srs = 1'b1;
    bus.draw_background = 1'b0;
    @(negedge clk);
    srs = 1'b0;
    checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL srst_plot got %b exp 0", bus.plot); end
    checks++; if (bus.done1 !== 1'b0) begin errors++; $display("FAIL srst_done1 got %b exp 0", bus.done1); end
    checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL srst_win got %b exp 0", bus.win); end
    repeat (3) @(negedge clk);
    checks++; if (bus.done1 !== 1'b0 || bus.plot !== 1'b0) begin
      errors++; $display("FAIL srst_quiet got done1=%b plot=%b exp 0,0", bus.done1, bus.plot); end
    bus.draw_car = 1'b1;
    collect(2, 3'b100);
    bus.draw_car = 1'b0;
    checks++; if (minx != 76 || miny != 108) begin errors++; $display("FAIL srst_pos got %0d,%0d exp 76,108", minx, miny); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.draw_car = 1'b1;
    bus.draw_win_screen = 1'b1;
    collect(5, 3'b110);
    bus.draw_win_screen = 1'b0;
    checks++; if (n_plot != 19200 || timed_out != 0) begin errors++; $display("FAIL prio_win_count got %0d exp 19200", n_plot); end
    checks++; if (n_badcol != 0) begin errors++; $display("FAIL prio_win_colour got %0d bad exp 0", n_badcol); end
    checks++; if (bus.done2 !== 1'b0) begin errors++; $display("FAIL prio_car_early got %b exp 0", bus.done2); end
    collect(2, 3'b100);
    bus.draw_car = 1'b0;
    checks++; if (n_plot != 64 || n_badcol != 0) begin
      errors++; $display("FAIL prio_car got n=%0d bad=%0d exp 64,0", n_plot, n_badcol); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL prio_car_start got %0d exp 2", first_cyc); end
    checks++; if (fx != 76 || fy != 108) begin errors++; $display("FAIL prio_car_origin got %0d,%0d exp 76,108", fx, fy); end
  endtask

  initial begin
    reset = 1'b1; srs = 1'b0;
    bus.draw_background = 1'b0; bus.draw_car = 1'b0; bus.draw_new_background = 1'b0;
    bus.draw_new_car = 1'b0; bus.draw_win_screen = 1'b0;
    bus.move = 1'b0; bus.forward = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
    test_reset();
    test_background();
    test_car();
    test_clamp();
    test_move_to_win();
    test_soft_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
